pro_fcl_ctrl: RTL and testbench
===============================

# pro_fcl_ctrl

Sequencer for the binarized fully-connected PE array. It streams one input vector and the matching binary weight columns from two synchronous SRAMs into the PE array, one element per cycle. It drives the array's accumulate-clear, shift and operand ports, then captures each group of `PRO_PARALLEL` neuron outputs. Captured groups are delivered downstream on a valid/ready port until all `OUT_CNT` neurons of the layer are produced.

## Interface
- `PRO_WIDTH`, 8, pixel / output lane width
- `PRO_PARALLEL`, 16, PEs in the array (neurons per group)
- `ACC_WIDTH`, 24, PE accumulator width (sizes shift)
- `IN_LEN`, 784, input elements per vector (≥2)
- `OUT_CNT`, 64, neurons per layer; must be a multiple of `PRO_PARALLEL`; `G = OUT_CNT/PRO_PARALLEL`
- `clk`  in  1  clock; single clock domain
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  begin a layer pass; ignored while `busy`
- `shift_cfg`  in  $clog2(ACC_WIDTH)  output right-shift, latched on accepted `start`
- `busy`  out  1  high from accepted `start` through the `done` cycle
- `done`  out  1  one-cycle pulse after the last group handshake
- `in_re`  out  1  input SRAM read enable
- `in_addr`  out  $clog2(IN_LEN)  input SRAM address
- `in_data`  in  PRO_WIDTH  input SRAM data, valid 1 cycle after `in_re`
- `w_re`  out  1  weight SRAM read enable
- `w_addr`  out  $clog2(IN_LEN*G)  weight SRAM address
- `w_data`  in  PRO_PARALLEL  weight bits, valid 1 cycle after `w_re`
- `pe_in`  out  PRO_WIDTH  to array `INPUT`; equals `in_data`
- `pe_w`  out  PRO_PARALLEL  to array `W`; equals `w_data`
- `pe_acc`  out  1  to array `rst`: 0 = load, 1 = accumulate
- `pe_shift`  out  $clog2(ACC_WIDTH)  to array `shift`
- `pe_out`  in  PRO_PARALLEL*PRO_WIDTH  array `OUTPUT`, combinational from acc
- `out_valid`  out  1  captured group available
- `out_ready`  in  1  downstream accepts
- `out_data`  out  PRO_PARALLEL*PRO_WIDTH  captured lanes, lane i at bits [i*PRO_WIDTH +: PRO_WIDTH]
- `out_group`  out  $clog2(G)  group index of `out_data`

## Operation
- FSM states: IDLE, STREAM, DRAIN, OUT, DONE.
- **IDLE.** On `start`, latch `shift_cfg` into `pe_shift`, set group g=0 and k=0, then go to STREAM.
- **STREAM.** Lasts `IN_LEN` cycles.
  - Each cycle: `in_re`=`w_re`=1, `in_addr`=k, `w_addr`=g*IN_LEN+k, then k++.
  - After k=IN_LEN-1 is issued, go to DRAIN.
- **`pe_acc` generation.** `pe_acc` is a one-cycle-delayed flag.
  - It is 1 exactly in the cycles where the data returned for k≥1 is present.
  - It is 0 in the k=0 data cycle and in all other cycles. The array therefore reloads on element 0 and accumulates on the rest.
- **DRAIN.** Lasts one cycle; the last element is accumulated at the end of it.
- **OUT.**
  - On entry, capture `pe_out` into `out_data` and set `out_valid`=1, `out_group`=g.
  - Hold `out_data` stable until `out_valid && out_ready`.
  - On that handshake: if g<G-1, then g++, k=0, and go to STREAM; otherwise go to DONE.
- **DONE.** Lasts one cycle with `done`=1, then go to IDLE.
- **Simultaneous `start` + `done`.** `start` is ignored; a new `start` is accepted only in IDLE.
- **Reset (async, including mid-pass).** All outputs go to 0, `pe_shift` goes to 0, and the FSM goes to IDLE. The array state is don't-care, because the next pass reloads it with `pe_acc`=0.

## Timing
- STREAM cycle 0 issues address 0. Data element k is present at cycle k+1.
- The array accumulator is final after the edge ending cycle `IN_LEN`.
- DRAIN is cycle `IN_LEN`. The capture edge ends cycle `IN_LEN+1`.
- `out_valid` rises in cycle `IN_LEN+2` after the group's first STREAM cycle.
- With `out_ready` tied high, each group occupies `IN_LEN+3` cycles.
- `done` comes 1 cycle after the last handshake.
- Backpressure: the FSM stalls in OUT indefinitely and issues no SRAM reads. `pe_acc` is 0 while stalled.

## Configuration
- `PRO_FCL_CTRL_RELU_EN` defined: at capture, any lane whose MSB is 1 is stored as 0.
- Not defined: lanes are stored unmodified (signed).

## Test plan
Bench settings: `IN_LEN`=4, `PRO_PARALLEL`=2, `OUT_CNT`=4, `PRO_WIDTH`=8, with a behavioural PE model.

- **Single pass.** `start`, `out_ready`=1.
  - `in_addr` must read 0,1,2,3 for each group.
  - `w_addr` must read 0..3 for group 0 and 4..7 for group 1.
  - `pe_acc` must read 0,1,1,1 on the data cycles.
  - `out_valid` must rise in cycle 6 for each group.
  - `done` comes 1 cycle after the group-1 handshake.
- **Arithmetic.**
  - Stimulus: in_data all 8'h01, w_data all 2'b11, `shift_cfg`=0.
  - Required: `out_data` lanes equal the model's sum.
  - Check `pe_shift` equals the latched value, even if `shift_cfg` changes mid-pass.
- **Backpressure.**
  - Stimulus: `out_ready`=0 for 10 cycles on group 0.
  - Required: `out_data` and `out_group`=0 stay stable, with no `in_re`/`w_re`.
  - Group 1 STREAM starts the cycle after `out_ready` rises.
- **Start filtering.**
  - `start` pulsed during STREAM and in the `done` cycle must be ignored; `busy` stays high through `done` only.
  - A `start` the cycle after `done` must start a new pass.
- **Reset mid-operation.**
  - Assert `rst` mid-STREAM of group 1.
  - Required: all outputs are 0 immediately (async).
  - A pass after release restarts at g=0 with `w_addr`=0.
- **Configuration.**
  - Stimulus: stub `pe_out` lanes = 8'h85 and 8'h12.
  - Required: `out_data`={8'h12,8'h85} without `PRO_FCL_CTRL_RELU_EN`, and {8'h12,8'h00} with it.

Source files
------------

// File: rtl/pro_fcl_ctrl_if.sv
// Bundle of the pro_fcl_ctrl control, SRAM, PE-array and output-stream signals.
// The master modport is the sequencer side. The slave modport is the environment side.
interface pro_fcl_ctrl_if #(
  parameter int unsigned PRO_WIDTH    = 8,
  parameter int unsigned PRO_PARALLEL = 16,
  parameter int unsigned ACC_WIDTH    = 24,
  parameter int unsigned IN_LEN       = 784,
  parameter int unsigned OUT_CNT      = 64
);
  localparam int unsigned G   = OUT_CNT / PRO_PARALLEL;
  localparam int unsigned SW  = $clog2(ACC_WIDTH);
  localparam int unsigned AW  = $clog2(IN_LEN);
  localparam int unsigned WAW = (IN_LEN * G > 1) ? $clog2(IN_LEN * G) : 1;
  localparam int unsigned GW  = (G > 1) ? $clog2(G) : 1;
  localparam int unsigned DW  = PRO_PARALLEL * PRO_WIDTH;

  logic                    start;
  logic [SW-1:0]           shift_cfg;
  logic                    busy;
  logic                    done;
  logic                    in_re;
  logic [AW-1:0]           in_addr;
  logic [PRO_WIDTH-1:0]    in_data;
  logic                    w_re;
  logic [WAW-1:0]          w_addr;
  logic [PRO_PARALLEL-1:0] w_data;
  logic [PRO_WIDTH-1:0]    pe_in;
  logic [PRO_PARALLEL-1:0] pe_w;
  logic                    pe_acc;
  logic [SW-1:0]           pe_shift;
  logic [DW-1:0]           pe_out;
  logic                    out_valid;
  logic                    out_ready;
  logic [DW-1:0]           out_data;
  logic [GW-1:0]           out_group;

  modport master (
    input  start, shift_cfg, in_data, w_data, pe_out, out_ready,
    output busy, done, in_re, in_addr, w_re, w_addr, pe_in, pe_w, pe_acc, pe_shift,
           out_valid, out_data, out_group
  );

  modport slave (
    output start, shift_cfg, in_data, w_data, pe_out, out_ready,
    input  busy, done, in_re, in_addr, w_re, w_addr, pe_in, pe_w, pe_acc, pe_shift,
           out_valid, out_data, out_group
  );
endinterface

// File: rtl/pro_fcl_ctrl.sv
// Sequencer for the binarized FC PE array: it streams SRAM operands and captures neuron groups.
// When PRO_FCL_CTRL_RELU_EN is defined, negative lanes are zeroed at capture.
module pro_fcl_ctrl #(
  parameter int unsigned PRO_WIDTH    = 8,
  parameter int unsigned PRO_PARALLEL = 16,
  parameter int unsigned ACC_WIDTH    = 24,
  parameter int unsigned IN_LEN       = 784,
  parameter int unsigned OUT_CNT      = 64
) (
  input  logic           i_clk,
  input  logic           i_rst,
  pro_fcl_ctrl_if.master io_bus
);
  localparam int unsigned G   = OUT_CNT / PRO_PARALLEL;
  localparam int unsigned SW  = $clog2(ACC_WIDTH);
  localparam int unsigned AW  = $clog2(IN_LEN);
  localparam int unsigned WAW = (IN_LEN * G > 1) ? $clog2(IN_LEN * G) : 1;
  localparam int unsigned GW  = (G > 1) ? $clog2(G) : 1;
  localparam int unsigned DW  = PRO_PARALLEL * PRO_WIDTH;

  typedef enum logic [2:0] {StIdle, StStream, StDrain, StOut, StDone} state_e;

  state_e            r_state, w_state_nxt;
  logic [AW-1:0]     r_k;
  logic [WAW-1:0]    r_waddr;
  logic [GW-1:0]     r_g;
  logic [SW-1:0]     r_shift;
  logic              r_acc;
  logic              r_dv;
  logic              r_out_valid;
  logic [DW-1:0]     r_out_data;
  logic [GW-1:0]     r_out_group;
  logic              w_stream, w_k_last, w_g_last, w_hs;
  logic [DW-1:0]     w_cap;

  assign w_stream = (r_state == StStream);
  assign w_k_last = (r_k == AW'(IN_LEN - 1));
  assign w_g_last = (r_g == GW'(G - 1));
  assign w_hs     = r_out_valid & io_bus.out_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= StIdle;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:   if (io_bus.start) w_state_nxt = StStream;
      StStream: if (w_k_last) w_state_nxt = StDrain;
      StDrain:  w_state_nxt = StOut;
      StOut:    if (w_hs) w_state_nxt = w_g_last ? StDone : StStream;
      StDone:   w_state_nxt = StIdle;
      default:  w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    io_bus.busy      = (r_state != StIdle);
    io_bus.done      = (r_state == StDone);
    io_bus.in_re     = w_stream;
    io_bus.w_re      = w_stream;
    io_bus.in_addr   = w_stream ? r_k : '0;
    io_bus.w_addr    = w_stream ? r_waddr : '0;
    // Operands are forwarded only while returned SRAM data is live, so they read 0 otherwise.
    io_bus.pe_in     = r_dv ? io_bus.in_data : '0;
    io_bus.pe_w      = r_dv ? io_bus.w_data : '0;
    io_bus.pe_acc    = r_acc;
    io_bus.pe_shift  = r_shift;
    io_bus.out_valid = r_out_valid;
    io_bus.out_data  = r_out_data;
    io_bus.out_group = r_out_group;
  end

  always_comb begin
    w_cap = io_bus.pe_out;
`ifdef PRO_FCL_CTRL_RELU_EN
    for (int i = 0; i < int'(PRO_PARALLEL); i++) begin
      if (io_bus.pe_out[i*PRO_WIDTH + PRO_WIDTH - 1]) w_cap[i*PRO_WIDTH +: PRO_WIDTH] = '0;
    end
`endif
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_k         <= '0;
      r_waddr     <= '0;
      r_g         <= '0;
      r_shift     <= '0;
      r_acc       <= 1'b0;
      r_dv        <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_group <= '0;
    end else begin
      // Element 0 reloads the array; every later element accumulates.
      r_acc <= w_stream && (r_k != '0);
      r_dv  <= w_stream;
      unique case (r_state)
        StIdle: begin
          if (io_bus.start) begin
            r_shift <= io_bus.shift_cfg;
            r_g     <= '0;
            r_k     <= '0;
            r_waddr <= '0;
          end
        end
        StStream: begin
          r_k     <= w_k_last ? '0 : r_k + 1'b1;
          r_waddr <= r_waddr + 1'b1;
        end
        StOut: begin
          if (!r_out_valid) begin
            r_out_data  <= w_cap;
            r_out_valid <= 1'b1;
            r_out_group <= r_g;
          end else if (io_bus.out_ready) begin
            r_out_valid <= 1'b0;
            if (!w_g_last) r_g <= r_g + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_pro_fcl_ctrl.sv
// Directed bench for pro_fcl_ctrl with SRAM and behavioural PE models (IN_LEN=4, 2 PEs, 2 groups).
// Expected capture values follow PRO_FCL_CTRL_RELU_EN when it is defined.
module tb_pro_fcl_ctrl;
  localparam int unsigned PW = 8, PP = 2, AWD = 24, IL = 4, OC = 4;
`ifdef PRO_FCL_CTRL_RELU_EN
  localparam logic [15:0] EXP_G0 = 16'h000A, EXP_G1 = 16'h0A00, EXP_STUB = 16'h1200;
`else
  localparam logic [15:0] EXP_G0 = 16'hF60A, EXP_G1 = 16'h0AF6, EXP_STUB = 16'h1285;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pro_fcl_ctrl_if #(.PRO_WIDTH(PW), .PRO_PARALLEL(PP), .ACC_WIDTH(AWD), .IN_LEN(IL),
                    .OUT_CNT(OC)) bus ();

  pro_fcl_ctrl #(.PRO_WIDTH(PW), .PRO_PARALLEL(PP), .ACC_WIDTH(AWD), .IN_LEN(IL),
                 .OUT_CNT(OC)) dut (.i_clk(clk), .i_rst(rst), .io_bus(bus));

  logic [7:0]         in_mem [4];
  logic [1:0]         w_mem  [8];
  logic signed [23:0] acc    [2];
  logic [15:0]        model_out;
  logic               use_stub;
  int                 n_cmp = 0;
  int                 n_err = 0;

  always @(posedge clk) begin
    if (bus.in_re) bus.in_data <= in_mem[bus.in_addr];
    if (bus.w_re)  bus.w_data  <= w_mem[bus.w_addr];
  end

  // Binary weight 1 adds the pixel and 0 subtracts it.
  function automatic logic signed [23:0] pe_term(input logic [7:0] x, input logic w);
    logic signed [23:0] v;
    v = $signed({16'd0, x});
    return w ? v : -v;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < int'(PP); i++)
      acc[i] <= bus.pe_acc ? acc[i] + pe_term(bus.pe_in, bus.pe_w[i]) : pe_term(bus.pe_in, bus.pe_w[i]);
  end

  always_comb begin
    model_out = '0;
    for (int i = 0; i < int'(PP); i++) model_out[i*PW +: PW] = 8'(acc[i] >>> bus.pe_shift);
  end

  assign bus.pe_out = use_stub ? 16'h1285 : model_out;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic start_pass(input logic [4:0] s);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.shift_cfg = s;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Checks group-relative cycles 0..ncyc-1. A start pulse is driven in cycle pulse_c.
  task automatic run_stream(input int g, input int pulse_c, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (c < 4) begin
        check_eq("in_re", 32'(bus.in_re), 32'd1);
        check_eq("w_re", 32'(bus.w_re), 32'd1);
        check_eq("in_addr", 32'(bus.in_addr), 32'(c));
        check_eq("w_addr", 32'(bus.w_addr), 32'(g * 4 + c));
      end else begin
        check_eq("in_re_idle", 32'(bus.in_re), 32'd0);
      end
      if (c >= 1) check_eq("pe_acc", 32'(bus.pe_acc), 32'((c >= 2 && c <= 4) ? 1 : 0));
      check_eq("out_valid_low", 32'(bus.out_valid), 32'd0);
      check_eq("busy", 32'(bus.busy), 32'd1);
      bus.start = (c == pulse_c);
    end
    bus.start = 1'b0;
  endtask

  task automatic wait_valid(input int g, input logic [15:0] exp, input logic [4:0] sh);
    @(negedge clk);
    check_eq("out_valid", 32'(bus.out_valid), 32'd1);
    check_eq("out_data", 32'(bus.out_data), 32'(exp));
    check_eq("out_group", 32'(bus.out_group), 32'(g));
    check_eq("pe_shift", 32'(bus.pe_shift), 32'(sh));
    check_eq("pe_acc_out", 32'(bus.pe_acc), 32'd0);
  endtask

  task automatic check_done();
    @(negedge clk);
    check_eq("done", 32'(bus.done), 32'd1);
    check_eq("busy_done", 32'(bus.busy), 32'd1);
  endtask

  task automatic fill(input logic varied);
    for (int i = 0; i < 4; i++) in_mem[i] = varied ? 8'(i + 1) : 8'h01;
    for (int i = 0; i < 8; i++) w_mem[i] = varied ? ((i < 4) ? 2'b01 : 2'b10) : 2'b11;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start     = 1'b0;
    bus.shift_cfg = '0;
    bus.out_ready = 1'b1;
    use_stub      = 1'b0;
    fill(1'b0);
    repeat (2) @(negedge clk);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_done", 32'(bus.done), 32'd0);
    check_eq("rst_in_re", 32'(bus.in_re), 32'd0);
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_pe_shift", 32'(bus.pe_shift), 32'd0);
    rst = 1'b0;

    // All-ones data; shift_cfg changes after acceptance and must not reach pe_shift.
    start_pass(5'd0);
    bus.shift_cfg = 5'd3;
    run_stream(0, -1, 6);
    wait_valid(0, 16'h0404, 5'd0);
    run_stream(1, -1, 6);
    wait_valid(1, 16'h0404, 5'd0);
    check_done();
    @(negedge clk);
    check_eq("idle_done", 32'(bus.done), 32'd0);
    check_eq("idle_busy", 32'(bus.busy), 32'd0);

    // Signed sums; start is pulsed in STREAM and in the done cycle, then held into IDLE.
    fill(1'b1);
    start_pass(5'd0);
    run_stream(0, 2, 6);
    wait_valid(0, EXP_G0, 5'd0);
    run_stream(1, -1, 6);
    wait_valid(1, EXP_G1, 5'd0);
    check_done();
    bus.start     = 1'b1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check_eq("start_in_done_busy", 32'(bus.busy), 32'd0);
    check_eq("start_in_done_done", 32'(bus.done), 32'd0);
    @(posedge clk);
    #1 bus.start = 1'b0;

    // Backpressure on group 0 for ten cycles.
    run_stream(0, -1, 6);
    wait_valid(0, EXP_G0, 5'd0);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check_eq("bp_valid", 32'(bus.out_valid), 32'd1);
      check_eq("bp_data", 32'(bus.out_data), 32'(EXP_G0));
      check_eq("bp_group", 32'(bus.out_group), 32'd0);
      check_eq("bp_in_re", 32'(bus.in_re), 32'd0);
      check_eq("bp_w_re", 32'(bus.w_re), 32'd0);
      check_eq("bp_pe_acc", 32'(bus.pe_acc), 32'd0);
    end
    bus.out_ready = 1'b1;
    run_stream(1, -1, 6);
    wait_valid(1, EXP_G1, 5'd0);
    check_done();

    // Asynchronous reset in the middle of the group-1 stream.
    fill(1'b0);
    start_pass(5'd1);
    run_stream(0, -1, 6);
    wait_valid(0, 16'h0202, 5'd1);
    run_stream(1, -1, 2);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_busy", 32'(bus.busy), 32'd0);
    check_eq("arst_done", 32'(bus.done), 32'd0);
    check_eq("arst_in_re", 32'(bus.in_re), 32'd0);
    check_eq("arst_w_re", 32'(bus.w_re), 32'd0);
    check_eq("arst_in_addr", 32'(bus.in_addr), 32'd0);
    check_eq("arst_w_addr", 32'(bus.w_addr), 32'd0);
    check_eq("arst_pe_acc", 32'(bus.pe_acc), 32'd0);
    check_eq("arst_pe_shift", 32'(bus.pe_shift), 32'd0);
    check_eq("arst_pe_in", 32'(bus.pe_in), 32'd0);
    check_eq("arst_pe_w", 32'(bus.pe_w), 32'd0);
    check_eq("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("arst_out_data", 32'(bus.out_data), 32'd0);
    check_eq("arst_out_group", 32'(bus.out_group), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Restart from group 0 with a stubbed array output for the capture path.
    use_stub = 1'b1;
    start_pass(5'd0);
    run_stream(0, -1, 6);
    wait_valid(0, EXP_STUB, 5'd0);
    run_stream(1, -1, 6);
    wait_valid(1, EXP_STUB, 5'd0);
    check_done();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
